// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, phase codes and default durations for traffic_seq.
// Contents: phase codes PH_*, one-hot state_t whose bit index equals its phase code,
// default duration constants DEF_*, and phase_of() mapping a one-hot state to its code.
package traffic_pkg;
  localparam logic [2:0] PH_AR_NS = 3'd0;
  localparam logic [2:0] PH_G_NS  = 3'd1;
  localparam logic [2:0] PH_Y_NS  = 3'd2;
  localparam logic [2:0] PH_AR_EW = 3'd3;
  localparam logic [2:0] PH_G_EW  = 3'd4;
  localparam logic [2:0] PH_Y_EW  = 3'd5;
  localparam logic [2:0] PH_FLASH = 3'd6;
  localparam int DEF_G_NS_MIN = 8;
  localparam int DEF_G_EW     = 6;
  localparam int DEF_Y_TIME   = 3;
  localparam int DEF_AR_TIME  = 1;
  localparam int DEF_CNT_W    = 8;
  // One-hot state: bit n set means phase code n.
  typedef enum logic [6:0] {
    S_AR_NS = 7'b0000001,
    S_G_NS  = 7'b0000010,
    S_Y_NS  = 7'b0000100,
    S_AR_EW = 7'b0001000,
    S_G_EW  = 7'b0010000,
    S_Y_EW  = 7'b0100000,
    S_FLASH = 7'b1000000
  } state_t;
  function automatic logic [2:0] phase_of(state_t s);
    case (s)
      S_G_NS:  return PH_G_NS;
      S_Y_NS:  return PH_Y_NS;
      S_AR_EW: return PH_AR_EW;
      S_G_EW:  return PH_G_EW;
      S_Y_EW:  return PH_Y_EW;
      S_FLASH: return PH_FLASH;
      default: return PH_AR_NS;
    endcase
  endfunction
endpackage

// File: rtl/traffic_seq_if.sv
// traffic_seq_if: sensor/tick inputs and lamp/debug outputs of the intersection sequencer.
// Signals: tick, ew_req, night (TRAFFIC_SEQ_FLASH_EN only) toward the sequencer;
// gns/yns/rns, gew/yew/rew lamps, phase[2:0], ew_wait from it.
// Modports: master = environment driving sensors, slave = traffic_seq.
interface traffic_seq_if;
  logic tick;
  logic ew_req;
`ifdef TRAFFIC_SEQ_FLASH_EN
  logic night;
`endif
  logic gns, yns, rns;
  logic gew, yew, rew;
  logic [2:0] phase;
  logic ew_wait;
`ifdef TRAFFIC_SEQ_FLASH_EN
  modport master (output tick, ew_req, night, input gns, yns, rns, gew, yew, rew, phase, ew_wait);
  modport slave (input tick, ew_req, night, output gns, yns, rns, gew, yew, rew, phase, ew_wait);
`else
  modport master (output tick, ew_req, input gns, yns, rns, gew, yew, rew, phase, ew_wait);
  modport slave (input tick, ew_req, output gns, yns, rns, gew, yew, rew, phase, ew_wait);
`endif
endinterface

// File: rtl/phase_timer.sv
// phase_timer: loadable tick-driven down-counter that stops at zero.
// Ports: clk, rst_n (async active-low, resets to RST_VAL), tick (count strobe),
// load/load_val (load wins over counting), zero (count is 0).
module phase_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (tick && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/traffic_seq.sv
// traffic_seq: timed NS/EW intersection sequencer with EW request latch and lamp decode.
// Ports: clk, rst_n (async active-low), bus (traffic_seq_if.slave: tick, ew_req,
// night when TRAFFIC_SEQ_FLASH_EN is defined, six lamps, phase, ew_wait).
// Optional feature: define TRAFFIC_SEQ_FLASH_EN for the night-flash state and night input.
module traffic_seq import traffic_pkg::*; #(
  parameter int G_NS_MIN = DEF_G_NS_MIN,
  parameter int G_EW     = DEF_G_EW,
  parameter int Y_TIME   = DEF_Y_TIME,
  parameter int AR_TIME  = DEF_AR_TIME,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic         clk,
  input logic         rst_n,
  traffic_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] LD_GNS = CNT_W'(G_NS_MIN - 1);
  localparam logic [CNT_W-1:0] LD_GEW = CNT_W'(G_EW - 1);
  localparam logic [CNT_W-1:0] LD_Y   = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] LD_AR  = CNT_W'(AR_TIME - 1);
  state_t state, nxt;
  logic zero, load, flash, night, ew_wait;
  logic [CNT_W-1:0] ld_val;
`ifdef TRAFFIC_SEQ_FLASH_EN
  assign night = bus.night;
`else
  assign night = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_AR_NS;
    else state <= nxt;
  // Exit conditions are only examined on a tick once the phase timer has run out.
  always_comb begin
    nxt = state;
    if (bus.tick && zero)
      case (state)
        S_AR_NS: nxt = night ? S_FLASH : S_G_NS;
        S_G_NS:  nxt = (ew_wait || night) ? S_Y_NS : S_G_NS;
        S_Y_NS:  nxt = S_AR_EW;
        S_AR_EW: nxt = night ? S_FLASH : S_G_EW;
        S_G_EW:  nxt = S_Y_EW;
        S_Y_EW:  nxt = S_AR_NS;
        S_FLASH: nxt = night ? S_FLASH : S_AR_NS;
        default: nxt = S_AR_NS;
      endcase
  end
  // Any state change reloads the timer; FLASH loads 0 so every tick re-checks night.
  assign load   = nxt != state;
  assign ld_val = nxt == S_G_NS ? LD_GNS :
                  nxt == S_G_EW ? LD_GEW :
                  (nxt == S_Y_NS || nxt == S_Y_EW) ? LD_Y :
                  nxt == S_FLASH ? '0 : LD_AR;
  phase_timer #(.CNT_W(CNT_W), .RST_VAL(LD_AR)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (bus.tick),
    .load     (load),
    .load_val (ld_val),
    .zero     (zero)
  );
  // Serving EW (entering G_EW) clears the request even if ew_req is high that cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ew_wait <= 1'b0;
    else ew_wait <= (load && nxt == S_G_EW) ? 1'b0 : (ew_wait | bus.ew_req);
`ifdef TRAFFIC_SEQ_FLASH_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flash <= 1'b0;
    else if (load && nxt == S_FLASH) flash <= 1'b1;
    else if (state == S_FLASH && bus.tick) flash <= ~flash;
`else
  assign flash = 1'b0;
`endif
  assign bus.gns     = state == S_G_NS;
  assign bus.yns     = state == S_Y_NS || (state == S_FLASH && flash);
  assign bus.rns     = state inside {S_AR_NS, S_AR_EW, S_G_EW, S_Y_EW};
  assign bus.gew     = state == S_G_EW;
  assign bus.yew     = state == S_Y_EW || (state == S_FLASH && flash);
  assign bus.rew     = state inside {S_AR_NS, S_AR_EW, S_G_NS, S_Y_NS};
  assign bus.phase   = phase_of(state);
  assign bus.ew_wait = ew_wait;
endmodule
